// File: rtl/int_to_fp_conv_pkg.sv
// Shared fp word constants, field helpers and converter state type.
// Also intended for the fp magnitude comparator and any fp adder.
package int_to_fp_conv_pkg;

  localparam int EXP_W  = 4;
  localparam int FRAC_W = 8;
  localparam int IN_W   = 2 ** EXP_W;
  localparam int MAG_W  = IN_W - 1;
  localparam int FP_W   = 1 + EXP_W + FRAC_W;

  localparam logic [FP_W-1:0] FP_ZERO   = '0;
  localparam logic [FP_W-1:0] FP_MAXMAG = {1'b1, {EXP_W{1'b1}}, {FRAC_W{1'b1}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } conv_state_t;

  function automatic logic fp_sign(input logic [FP_W-1:0] v);
    return v[FP_W-1];
  endfunction

  function automatic logic [EXP_W-1:0] fp_exp(input logic [FP_W-1:0] v);
    return v[FRAC_W +: EXP_W];
  endfunction

  function automatic logic [FRAC_W-1:0] fp_frac(input logic [FP_W-1:0] v);
    return v[FRAC_W-1:0];
  endfunction

  // Low bits of the negation equal the negation of the low bits, so -32768 yields 0 here.
  function automatic logic [MAG_W-1:0] abs_mag(input logic [IN_W-1:0] v);
    return v[IN_W-1] ? (~v[MAG_W-1:0] + 1'b1) : v[MAG_W-1:0];
  endfunction

endpackage

// File: rtl/int_to_fp_conv_if.sv
// Start/ready/done handshake and result bus of the integer-to-fp converter.
interface int_to_fp_conv_if;
  import int_to_fp_conv_pkg::*;

  logic            start;
  logic [IN_W-1:0] din;
  logic            ready;
  logic            done_tick;
  logic [FP_W-1:0] fp_out;
  logic            ovf;

  modport master (
    output start, din,
    input  ready, done_tick, fp_out, ovf
  );

  modport slave (
    input  start, din,
    output ready, done_tick, fp_out, ovf
  );

endinterface

// File: rtl/int_to_fp_conv.sv
// Sequential 16-bit two's-complement to 13-bit fp converter, one normalize shift per clock.
module int_to_fp_conv
  import int_to_fp_conv_pkg::*;
(
  input logic               clk,
  input logic               reset,
  int_to_fp_conv_if.slave   bus
);

  conv_state_t       state;
  logic              s;
  logic [MAG_W-1:0]  m;
  logic [EXP_W-1:0]  e;
  logic [FP_W-1:0]   fp_reg;
  logic              ovf_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      s       <= 1'b0;
      m       <= '0;
      e       <= '0;
      fp_reg  <= FP_ZERO;
      ovf_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            s <= bus.din[IN_W-1];
            m <= abs_mag(bus.din);
            e <= EXP_W'(MAG_W);
            if (bus.din == '0) begin
              fp_reg  <= FP_ZERO;
              ovf_reg <= 1'b0;
              state   <= DONE;
            end else if (bus.din == {1'b1, {MAG_W{1'b0}}}) begin
              // 2^15 has no representation; clamp to the largest negative magnitude
              fp_reg  <= FP_MAXMAG;
              ovf_reg <= 1'b1;
              state   <= DONE;
            end else begin
              state <= NORM;
            end
          end
        end
        NORM: begin
          // e==0 cannot occur for nonzero m; kept so the loop always terminates
          if (m[MAG_W-1] || e == '0) begin
            fp_reg  <= {s, e, m[MAG_W-1 -: FRAC_W]};
            ovf_reg <= 1'b0;
            state   <= DONE;
          end else begin
            m <= m << 1;
            e <= e - 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready     = (state == IDLE);
  assign bus.done_tick = (state == DONE);
  assign bus.fp_out    = fp_reg;
  assign bus.ovf       = ovf_reg;

endmodule
